mips_io_bridge: RTL and testbench

//  Data-bus decoder between the MIPS core's load/store port and the data RAM. Routes

---
 rtl/mips_io_bridge_pkg.sv | 21 ++
 rtl/mips_io_bridge_if.sv | 29 ++
 rtl/mips_io_bridge_timer.sv | 78 +++++++
 rtl/mips_io_bridge.sv | 89 ++++++++
 tb/tb_mips_io_bridge.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_io_bridge_pkg.sv
// Shared constants for the MIPS data-bus IO bridge: register byte offsets,
// CTRL bit positions and the default IO window base.
package mips_io_bridge_pkg;

   localparam logic [31:0] IOB_IO_BASE_DEFAULT = 32'hFFFF_0000;

   // Register byte offsets inside the 256-byte IO window
   localparam logic [7:0] IOB_CTRL     = 8'h00;
   localparam logic [7:0] IOB_LOAD     = 8'h04;
   localparam logic [7:0] IOB_COUNT    = 8'h08;
   localparam logic [7:0] IOB_STAT     = 8'h0C;
   localparam logic [7:0] IOB_PEND     = 8'h10;
   localparam logic [7:0] IOB_MASK     = 8'h14;
   localparam logic [7:0] IOB_PRESCALE = 8'h18;

   // CTRL register bit indices
   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQEN  = 2;

endpackage

// File: rtl/mips_io_bridge_if.sv
// Core load/store port plus RAM port of the IO bridge.
// Handshake: single-cycle access, no backpressure. An access happens in every
// cycle with memCe=1; stores commit at the rising clk edge ending that cycle,
// loads return rdData combinationally in the same cycle. The RAM side follows
// the same rule (ramCe/ramWr qualify ramAddr/ramWtData, ramRdData same cycle).
interface mips_io_bridge_if;
   logic        memCe;
   logic        memWr;
   logic [31:0] memAddr;
   logic [31:0] wtData;
   logic [31:0] rdData;
   logic        ramCe;
   logic        ramWr;
   logic [31:0] ramAddr;
   logic [31:0] ramWtData;
   logic [31:0] ramRdData;

   // Core + RAM side (drives requests, supplies RAM read data)
   modport master (
      output memCe, memWr, memAddr, wtData, ramRdData,
      input  rdData, ramCe, ramWr, ramAddr, ramWtData
   );

   // Bridge side
   modport slave (
      input  memCe, memWr, memAddr, wtData, ramRdData,
      output rdData, ramCe, ramWr, ramAddr, ramWtData
   );
endinterface

// File: rtl/mips_io_bridge_timer.sv
// iob_timer: programmable down-counter with one-shot / auto-reload modes.
// Optional prescaler compiled in with MIPS_IOB_PRESCALE_EN; without it the
// timer ticks every cycle and PRESCALE reads as zero.
module iob_timer
   import mips_io_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEn,      // IO store this cycle
   input  logic [5:0]  wrIdx,     // word index of the store
   input  logic [31:0] wrData,
   output logic [2:0]  ctrl,
   output logic [31:0] loadVal,
   output logic [31:0] countVal,
   output logic        expired,
   output logic [15:0] prescale
);

   logic ctrlWr, loadWr, countWr, statWr;
   logic tick, run, zeroHit;

   assign ctrlWr  = wrEn && ({wrIdx, 2'b00} == IOB_CTRL);
   assign loadWr  = wrEn && ({wrIdx, 2'b00} == IOB_LOAD);
   assign countWr = wrEn && ({wrIdx, 2'b00} == IOB_COUNT);
   assign statWr  = wrEn && ({wrIdx, 2'b00} == IOB_STAT);

`ifdef MIPS_IOB_PRESCALE_EN
   logic        preWr;
   logic [15:0] preCnt;

   assign preWr = wrEn && ({wrIdx, 2'b00} == IOB_PRESCALE);
   assign tick  = (preCnt == prescale);

   // Prescale divider: one tick every PRESCALE+1 cycles, restarted by CTRL/PRESCALE writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
         preCnt   <= '0;
      end else begin
         if (preWr) prescale <= wrData[15:0];
         if (ctrlWr || preWr || tick) preCnt <= '0;
         else                         preCnt <= preCnt + 16'd1;
      end
   end
`else
   assign tick     = 1'b1;
   assign prescale = '0;
`endif

   // A CTRL write that clears en suppresses this cycle's count step entirely
   assign run     = ctrl[CTRL_EN] && tick && !(ctrlWr && !wrData[CTRL_EN]);
   assign zeroHit = run && (countVal == 32'd0);

   // Counter, control and sticky expiry flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl     <= '0;
         loadVal  <= '0;
         countVal <= '0;
         expired  <= 1'b0;
      end else begin
         if (loadWr) loadVal <= wrData;

         // Software COUNT write outranks decrement and reload
         if (countWr)      countVal <= wrData;
         else if (zeroHit) countVal <= ctrl[CTRL_AUTO] ? loadVal : countVal;
         else if (run)     countVal <= countVal - 32'd1;

         if (ctrlWr)                          ctrl <= wrData[2:0];
         else if (zeroHit && !ctrl[CTRL_AUTO]) ctrl[CTRL_EN] <= 1'b0;

         // New expiry outranks a same-cycle W1C
         if (zeroHit)                   expired <= 1'b1;
         else if (statWr && wrData[0])  expired <= 1'b0;
      end
   end

endmodule

// File: rtl/mips_io_bridge.sv
// mips_io_bridge: routes core loads/stores to data RAM or to the peripheral
// register bank (timer + 6-line interrupt latch). Optional prescaler is
// enabled by defining MIPS_IOB_PRESCALE_EN.
module mips_io_bridge
   import mips_io_bridge_pkg::*;
#(
   parameter logic [31:0] IO_BASE  = IOB_IO_BASE_DEFAULT,
   parameter int          IRQ_SYNC = 2
) (
   input  logic             clk,
   input  logic             rst,
   mips_io_bridge_if.slave  bus,
   input  logic [5:0]       extIrq,
   output logic [5:0]       intr,
   output logic             intimer
);

   logic        ioSel, ioWr;
   logic [5:0]  regIdx;
   logic [2:0]  ctrl;
   logic [31:0] loadVal, countVal;
   logic        expired;
   logic [15:0] prescale;
   logic [5:0]  pend, mask, irqPrev, irqRise, pendClr;
   logic [IRQ_SYNC-1:0][5:0] syncQ;
   logic [31:0] regRd;

   assign ioSel  = (bus.memAddr[31:8] == IO_BASE[31:8]);
   assign ioWr   = bus.memCe && bus.memWr && ioSel;
   assign regIdx = bus.memAddr[7:2];

   assign bus.ramCe     = bus.memCe && !ioSel;
   assign bus.ramWr     = bus.memWr && !ioSel;
   assign bus.ramAddr   = bus.memAddr;
   assign bus.ramWtData = bus.wtData;

   iob_timer uTimer (
      .clk      (clk),
      .rst      (rst),
      .wrEn     (ioWr),
      .wrIdx    (regIdx),
      .wrData   (bus.wtData),
      .ctrl     (ctrl),
      .loadVal  (loadVal),
      .countVal (countVal),
      .expired  (expired),
      .prescale (prescale)
   );

   assign irqRise = syncQ[IRQ_SYNC-1] & ~irqPrev;
   assign pendClr = (ioWr && ({regIdx, 2'b00} == IOB_PEND)) ? bus.wtData[5:0] : 6'd0;

   // IRQ synchroniser, edge latch, mask and registered CP0 outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncQ   <= '0;
         irqPrev <= '0;
         pend    <= '0;
         mask    <= '0;
         intr    <= '0;
         intimer <= 1'b0;
      end else begin
         syncQ   <= {syncQ[IRQ_SYNC-2:0], extIrq};
         irqPrev <= syncQ[IRQ_SYNC-1];
         pend    <= (pend & ~pendClr) | irqRise;   // set wins over W1C
         if (ioWr && ({regIdx, 2'b00} == IOB_MASK)) mask <= bus.wtData[5:0];
         intr    <= pend & mask;
         intimer <= expired & ctrl[CTRL_IRQEN];
      end
   end

   // Register-bank read mux; unmapped offsets read zero
   always_comb begin
      regRd = '0;
      case ({regIdx, 2'b00})
         IOB_CTRL:     regRd = {29'd0, ctrl};
         IOB_LOAD:     regRd = loadVal;
         IOB_COUNT:    regRd = countVal;
         IOB_STAT:     regRd = {31'd0, expired};
         IOB_PEND:     regRd = {26'd0, pend};
         IOB_MASK:     regRd = {26'd0, mask};
         IOB_PRESCALE: regRd = {16'd0, prescale};
         default:      regRd = '0;
      endcase
   end

   assign bus.rdData = bus.memCe ? (ioSel ? regRd : bus.ramRdData) : 32'd0;

endmodule

// File: tb/tb_mips_io_bridge.sv
// Bench for mips_io_bridge; the prescaler scenario is built when
// MIPS_IOB_PRESCALE_EN is defined.
module tb_mips_io_bridge;
   import mips_io_bridge_pkg::*;

   localparam int          IRQ_SYNC = 2;
   localparam logic [31:0] IOB      = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  extIrq;
   logic [5:0]  intr;
   logic        intimer;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ramMem[64];
   logic [31:0] model[64];

   mips_io_bridge_if bus();

   mips_io_bridge #(.IO_BASE(IOB), .IRQ_SYNC(IRQ_SYNC)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .extIrq  (extIrq),
      .intr    (intr),
      .intimer (intimer)
   );

   // clock / reset-cleared RAM model behind the bridge
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ramMem[i] <= '0;
      end else if (bus.ramCe && bus.ramWr) begin
         ramMem[bus.ramAddr[7:2]] <= bus.ramWtData;
      end
   end
   assign bus.ramRdData = ramMem[bus.ramAddr[7:2]];

   // driver tasks
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.memCe = 1'b1; bus.memWr = 1'b1; bus.memAddr = addr; bus.wtData = data;
      step();
      bus.memCe = 1'b0; bus.memWr = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] d);
      bus.memCe = 1'b1; bus.memWr = 1'b0; bus.memAddr = addr;
      #1;
      d = bus.rdData;
      bus.memCe = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [7:0]  offs[7];
      offs = '{IOB_CTRL, IOB_LOAD, IOB_COUNT, IOB_STAT, IOB_PEND, IOB_MASK, IOB_PRESCALE};
      rst = 1'b1; extIrq = '0;
      bus.memCe = 1'b0; bus.memWr = 1'b0; bus.memAddr = '0; bus.wtData = '0;
      step(3);
      checks++; if (intr !== 6'd0) begin failures++; $display("FAIL reset_intr: got %h expected 00", intr); end
      checks++; if (intimer !== 1'b0) begin failures++; $display("FAIL reset_intimer: got %b expected 0", intimer); end
      for (int i = 0; i < 7; i++) begin
         rd(IOB | {24'd0, offs[i]}, d);
         checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0", i, d); end
      end
      @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = '0;
   endtask

   task automatic test_ram_pass();
      logic [31:0] d, a, v;
      int idx;
      bus.memCe = 1'b1; bus.memWr = 1'b1; bus.memAddr = 32'h0000_0040; bus.wtData = 32'h1234_5678;
      #1;
      checks++; if ({bus.ramCe, bus.ramWr} !== 2'b11) begin failures++; $display("FAIL ram_strobe: got %b expected 11", {bus.ramCe, bus.ramWr}); end
      checks++; if (bus.ramAddr !== 32'h40 || bus.ramWtData !== 32'h1234_5678) begin failures++;
         $display("FAIL ram_pass: got %h/%h expected 00000040/12345678", bus.ramAddr, bus.ramWtData); end
      step();
      bus.memCe = 1'b0; bus.memWr = 1'b0;
      model[16] = 32'h1234_5678;
      rd(32'h0000_0040, d);
      checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL ram_load: got %h expected 12345678", d); end
      // IO access must not touch RAM
      bus.memCe = 1'b1; bus.memWr = 1'b1; bus.memAddr = IOB | 32'h44; bus.wtData = 32'hDEAD_BEEF;
      #1;
      checks++; if ({bus.ramCe, bus.ramWr} !== 2'b00) begin failures++; $display("FAIL ram_io_ce: got %b expected 00", {bus.ramCe, bus.ramWr}); end
      step();
      bus.memCe = 1'b0; bus.memWr = 1'b0;
      #1;
      checks++; if (bus.rdData !== 32'd0) begin failures++; $display("FAIL rd_idle: got %h expected 0", bus.rdData); end
      // random stores then loads through the scoreboard
      for (int i = 0; i < 8; i++) begin
         idx = $urandom_range(0, 63);
         v   = $urandom;
         model[idx] = v;
         a = {24'd0, idx[5:0], 2'b00};
         wr(a, v);
      end
      for (int i = 0; i < 8; i++) begin
         idx = $urandom_range(0, 63);
         a = {24'd0, idx[5:0], 2'b00};
         exp_q.push_back(model[idx]);
         rd(a, d);
         v = exp_q.pop_front();
         checks++; if (d !== v) begin failures++; $display("FAIL ram_rand @%h: got %h expected %h", a, d, v); end
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      int n;
      for (int r = 0; r < 3; r++) begin
         n = (r == 0) ? 3 : $urandom_range(1, 10);
         wr(IOB | IOB_COUNT, n);
         wr(IOB | IOB_CTRL, 32'h5);
         for (int k = 1; k <= n; k++) begin
            step();
            rd(IOB | IOB_COUNT, d);
            checks++; if (d !== 32'(n - k)) begin failures++; $display("FAIL os_count k=%0d: got %0d expected %0d", k, d, n - k); end
            rd(IOB | IOB_STAT, d);
            checks++; if (d !== 32'd0) begin failures++; $display("FAIL os_early k=%0d: got %h expected 0", k, d); end
         end
         step();
         rd(IOB | IOB_STAT, d);
         checks++; if (d !== 32'd1) begin failures++; $display("FAIL os_expired n=%0d: got %h expected 1", n, d); end
         rd(IOB | IOB_CTRL, d);
         checks++; if (d !== 32'h4) begin failures++; $display("FAIL os_ctrl: got %h expected 4", d); end
         checks++; if (intimer !== 1'b0) begin failures++; $display("FAIL os_intimer_lat: got %b expected 0", intimer); end
         step();
         checks++; if (intimer !== 1'b1) begin failures++; $display("FAIL os_intimer: got %b expected 1", intimer); end
         wr(IOB | IOB_STAT, 32'h1);
         wr(IOB | IOB_CTRL, 32'h0);
         checks++; if (intimer !== 1'b0) begin failures++; $display("FAIL os_intimer_clr: got %b expected 0", intimer); end
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] d;
      int l;
      for (int r = 0; r < 3; r++) begin
         l = (r == 0) ? 2 : $urandom_range(0, 4);
         wr(IOB | IOB_LOAD, l);
         wr(IOB | IOB_COUNT, l);
         wr(IOB | IOB_CTRL, 32'h7);
         step(l + 1);                       // first expiry edge, period l+1
         rd(IOB | IOB_STAT, d);
         checks++; if (d !== 32'd1) begin failures++; $display("FAIL ar_first L=%0d: got %h expected 1", l, d); end
         rd(IOB | IOB_COUNT, d);
         checks++; if (d !== 32'(l)) begin failures++; $display("FAIL ar_reload: got %0d expected %0d", d, l); end
         step(l);
         wr(IOB | IOB_STAT, 32'h1);         // lands on the second expiry edge
         rd(IOB | IOB_STAT, d);
         checks++; if (d !== 32'd1) begin failures++; $display("FAIL ar_w1c_race L=%0d: got %h expected 1", l, d); end
         checks++; if (intimer !== 1'b1) begin failures++; $display("FAIL ar_intimer: got %b expected 1", intimer); end
         if (l > 0) begin
            wr(IOB | IOB_STAT, 32'h1);
            rd(IOB | IOB_STAT, d);
            checks++; if (d !== 32'd0) begin failures++; $display("FAIL ar_w1c L=%0d: got %h expected 0", l, d); end
            rd(IOB | IOB_COUNT, d);
            checks++; if (d !== 32'(l - 1)) begin failures++; $display("FAIL ar_count: got %0d expected %0d", d, l - 1); end
         end
         wr(IOB | IOB_CTRL, 32'h0);
         wr(IOB | IOB_STAT, 32'h1);
         step();
      end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      // CTRL write clearing en on the one-shot expiry edge: no expiry
      wr(IOB | IOB_COUNT, 32'd0);
      wr(IOB | IOB_CTRL, 32'h1);
      wr(IOB | IOB_CTRL, 32'h0);
      rd(IOB | IOB_STAT, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL pri_ctrl_stat: got %h expected 0", d); end
      rd(IOB | IOB_CTRL, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL pri_ctrl: got %h expected 0", d); end
      // COUNT write beats decrement
      wr(IOB | IOB_COUNT, 32'd50);
      wr(IOB | IOB_CTRL, 32'h1);
      step(3);
      rd(IOB | IOB_COUNT, d);
      checks++; if (d !== 32'd47) begin failures++; $display("FAIL pri_run: got %0d expected 47", d); end
      wr(IOB | IOB_COUNT, 32'd20);
      rd(IOB | IOB_COUNT, d);
      checks++; if (d !== 32'd20) begin failures++; $display("FAIL pri_count_wr: got %0d expected 20", d); end
      step();
      rd(IOB | IOB_COUNT, d);
      checks++; if (d !== 32'd19) begin failures++; $display("FAIL pri_after: got %0d expected 19", d); end
      wr(IOB | IOB_CTRL, 32'h0);
      // unmapped offset reads zero
      wr(IOB | 32'h20, 32'hFFFF_FFFF);
      rd(IOB | 32'h20, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped: got %h expected 0", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      logic [5:0]  m, b;
      for (int r = 0; r < 4; r++) begin
         m = (r == 0) ? 6'h05 : 6'($urandom_range(0, 63));
         b = (r == 0) ? 6'h03 : 6'($urandom_range(1, 63));
         wr(IOB | IOB_MASK, {26'd0, m});
         extIrq = b;
         step();
         extIrq = '0;
         step();
         checks++; if (intr !== 6'd0) begin failures++; $display("FAIL irq_early: got %h expected 00", intr); end
         step();
         rd(IOB | IOB_PEND, d);
         checks++; if (d !== {26'd0, b}) begin failures++; $display("FAIL irq_pend: got %h expected %h", d, b); end
         step();
         checks++; if (intr !== (b & m)) begin failures++; $display("FAIL irq_intr: got %h expected %h", intr, b & m); end
         wr(IOB | IOB_PEND, {26'd0, b});
         step();
         rd(IOB | IOB_PEND, d);
         checks++; if (d !== 32'd0 || intr !== 6'd0) begin failures++; $display("FAIL irq_w1c: got %h/%h expected 0/0", d, intr); end
      end
   endtask

   task automatic test_irq_set_wins();
      logic [31:0] d;
      logic [5:0]  b;
      b = 6'(1 << $urandom_range(0, 5));
      extIrq = b;
      step();
      extIrq = '0;
      step();
      wr(IOB | IOB_PEND, {26'd0, b});      // same edge as the latch set
      rd(IOB | IOB_PEND, d);
      checks++; if (d !== {26'd0, b}) begin failures++; $display("FAIL irq_set_wins: got %h expected %h", d, b); end
      wr(IOB | IOB_PEND, {26'd0, b});
      rd(IOB | IOB_PEND, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL irq_clr: got %h expected 0", d); end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      logic [7:0]  offs[7];
      offs = '{IOB_CTRL, IOB_LOAD, IOB_COUNT, IOB_STAT, IOB_PEND, IOB_MASK, IOB_PRESCALE};
      wr(IOB | IOB_MASK, 32'h3F);
      extIrq = 6'h01;
      step();
      extIrq = '0;
      step(3);
      wr(IOB | IOB_LOAD, 32'd7);
      wr(IOB | IOB_COUNT, 32'd100);
      wr(IOB | IOB_CTRL, 32'h5);
      step(10);
      rd(IOB | IOB_COUNT, d);
      checks++; if (d !== 32'd90) begin failures++; $display("FAIL rm_precount: got %0d expected 90", d); end
      checks++; if (intr !== 6'h01) begin failures++; $display("FAIL rm_preintr: got %h expected 01", intr); end
      #2 rst = 1'b1;
      #1;
      checks++; if (intr !== 6'd0 || intimer !== 1'b0) begin failures++; $display("FAIL rm_outputs: got %h/%b expected 00/0", intr, intimer); end
      for (int i = 0; i < 7; i++) begin
         rd(IOB | {24'd0, offs[i]}, d);
         checks++; if (d !== 32'd0) begin failures++; $display("FAIL rm_reg%0d: got %h expected 0", i, d); end
      end
      @(posedge clk); #1; rst = 1'b0;
      step(2);
   endtask

   task automatic test_prescale();
      logic [31:0] d;
`ifdef MIPS_IOB_PRESCALE_EN
      wr(IOB | IOB_PRESCALE, 32'd3);
      rd(IOB | IOB_PRESCALE, d);
      checks++; if (d !== 32'd3) begin failures++; $display("FAIL ps_reg: got %h expected 3", d); end
      wr(IOB | IOB_COUNT, 32'd1);
      wr(IOB | IOB_CTRL, 32'h1);
      step(7);
      rd(IOB | IOB_STAT, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL ps_early: got %h expected 0", d); end
      step();
      rd(IOB | IOB_STAT, d);
      checks++; if (d !== 32'd1) begin failures++; $display("FAIL ps_expire: got %h expected 1", d); end
      wr(IOB | IOB_PRESCALE, 32'd0);
      wr(IOB | IOB_STAT, 32'h1);
`else
      wr(IOB | IOB_PRESCALE, 32'h0000_FFFF);
      rd(IOB | IOB_PRESCALE, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL ps_absent: got %h expected 0", d); end
      wr(IOB | IOB_COUNT, 32'd1);
      wr(IOB | IOB_CTRL, 32'h1);
      step(2);
      rd(IOB | IOB_STAT, d);
      checks++; if (d !== 32'd1) begin failures++; $display("FAIL ps_tick1: got %h expected 1", d); end
      wr(IOB | IOB_STAT, 32'h1);
`endif
   endtask

   initial begin
      test_reset();
      test_ram_pass();
      test_oneshot();
      test_autoreload();
      test_priority();
      test_irq();
      test_irq_set_wins();
      test_prescale();
      test_reset_midcount();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
